alarm_ring_ctrl: RTL and testbench

Sequencing controller for the alarm path: compares the running clock time against the alarm setting and drives the buzzer through ring, snooze and stop. Sits between the clock counter chain, the alarm-setting counters and the buzzer output. Snooze retargets are computed in BCD with minute and hour wrap, so the block needs no binary time representation. Runs on the system 10 Hz tick clock.

---
 rtl/alarm_ring_ctrl_if.sv | 26 ++
 rtl/alarm_ring_ctrl.sv | 138 +++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ring_ctrl_if.sv
// Alarm path bundle: clock/alarm BCD digits and buttons in, ring status and
// current ring target out.
interface alarm_ring_ctrl_if;
    logic [3:0] timeHourTens, timeHourMu, timeMinTens, timeMinMu;
    logic [3:0] alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu;
    logic       alarmOn, setActive, snoozeBtn, stopBtn;
    logic       ringing, snoozing, buzzer;
    logic [1:0] snoozeCount;
    logic [3:0] tgtHourTens, tgtHourMu, tgtMinTens, tgtMinMu;

    modport master (
        output timeHourTens, timeHourMu, timeMinTens, timeMinMu,
        output alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu,
        output alarmOn, setActive, snoozeBtn, stopBtn,
        input  ringing, snoozing, buzzer, snoozeCount,
        input  tgtHourTens, tgtHourMu, tgtMinTens, tgtMinMu
    );

    modport slave (
        input  timeHourTens, timeHourMu, timeMinTens, timeMinMu,
        input  alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu,
        input  alarmOn, setActive, snoozeBtn, stopBtn,
        output ringing, snoozing, buzzer, snoozeCount,
        output tgtHourTens, tgtHourMu, tgtMinTens, tgtMinMu
    );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: triggers on time==alarm, drives a 5 Hz buzzer, handles
// snooze retargeting in BCD and a lockout that blocks same-minute retrigger.
module alarm_ring_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_TICKS = 600,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              clk10hz,
    input  logic              nReset,
    alarm_ring_ctrl_if.slave  bus
);
    localparam logic [9:0] RING_LAST  = 10'(RING_TICKS - 1);
    localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);
    localparam logic [4:0] SNOOZE_ADD = 5'(SNOOZE_MIN);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, LOCKOUT} stateT;

    stateT       state, nextState;
    logic [9:0]  ringCnt, nextRingCnt;
    logic        beepPhase, nextBeep;
    logic [1:0]  snoozeCnt, nextSnoozeCnt;
    logic [15:0] tgt, nextTgt;
    logic        snoozePrev, stopPrev;
    logic [15:0] timeNow, alarmSet, snoozeTgt;
    logic        match, smatch, snoozeEdge, stopEdge;

    // Digit vectors are {hourTens, hourMu, minTens, minMu}
    assign timeNow  = {bus.timeHourTens, bus.timeHourMu, bus.timeMinTens, bus.timeMinMu};
    assign alarmSet = {bus.alarmHourTens, bus.alarmHourMu, bus.alarmMinTens, bus.alarmMinMu};
    assign match      = (timeNow == alarmSet);
    assign smatch     = (timeNow == tgt);
    assign snoozeEdge = bus.snoozeBtn & ~snoozePrev;
    assign stopEdge   = bus.stopBtn & ~stopPrev;

    logic [4:0] muSum;
    logic [3:0] newMinMu, newMinTens, newHourTens, newHourMu;
    logic       tensCarry, hourCarry;

    // Snooze target = now + SNOOZE_MIN, digit by digit so no binary time is needed
    always_comb begin
        muSum       = {1'b0, bus.timeMinMu} + SNOOZE_ADD;
        tensCarry   = (muSum >= 5'd10);
        newMinMu    = tensCarry ? 4'(muSum - 5'd10) : muSum[3:0];
        newMinTens  = bus.timeMinTens + {3'b000, tensCarry};
        hourCarry   = 1'b0;
        newHourTens = bus.timeHourTens;
        newHourMu   = bus.timeHourMu;
        if (newMinTens == 4'd6) begin
            newMinTens = 4'd0;
            hourCarry  = 1'b1;
        end
        if (hourCarry) begin
            if (bus.timeHourTens == 4'd2 && bus.timeHourMu == 4'd3) begin
                newHourTens = 4'd0;
                newHourMu   = 4'd0;
            end else if (bus.timeHourMu == 4'd9) begin
                newHourTens = bus.timeHourTens + 4'd1;
                newHourMu   = 4'd0;
            end else begin
                newHourMu   = bus.timeHourMu + 4'd1;
            end
        end
        snoozeTgt = {newHourTens, newHourMu, newMinTens, newMinMu};
    end

    always_comb begin
        nextState     = state;
        nextRingCnt   = ringCnt;
        nextBeep      = beepPhase;
        nextSnoozeCnt = snoozeCnt;
        nextTgt       = tgt;
        case (state)
            IDLE: begin
                nextTgt = alarmSet;
                if (match && bus.alarmOn && !bus.setActive) begin
                    nextState   = RINGING;
                    nextRingCnt = '0;
                    nextBeep    = 1'b1;
                end
            end
            RINGING: begin
                nextRingCnt = ringCnt + 10'd1;
                nextBeep    = ~beepPhase;
                if (stopEdge || !bus.alarmOn) begin
                    nextState = LOCKOUT;
                end else if (ringCnt == RING_LAST) begin
                    nextState = LOCKOUT;
                end else if (snoozeEdge && snoozeCnt < SNOOZE_MAX) begin
                    nextState     = SNOOZE;
                    nextTgt       = snoozeTgt;
                    nextSnoozeCnt = snoozeCnt + 2'd1;
                end
            end
            SNOOZE: begin
                if (stopEdge || !bus.alarmOn) begin
                    nextState = LOCKOUT;
                end else if (smatch) begin
                    nextState   = RINGING;
                    nextRingCnt = '0;
                    nextBeep    = 1'b1;
                end
            end
            LOCKOUT: begin
                nextTgt = alarmSet;
                if (!match) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Every exit to lockout ends the alarm event
        if (nextState == LOCKOUT) nextSnoozeCnt = '0;
    end

    always_ff @(posedge clk10hz or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            ringCnt    <= '0;
            beepPhase  <= 1'b0;
            snoozeCnt  <= '0;
            tgt        <= '0;
            snoozePrev <= 1'b0;
            stopPrev   <= 1'b0;
        end else begin
            state      <= nextState;
            ringCnt    <= nextRingCnt;
            beepPhase  <= nextBeep;
            snoozeCnt  <= nextSnoozeCnt;
            tgt        <= nextTgt;
            snoozePrev <= bus.snoozeBtn;
            stopPrev   <= bus.stopBtn;
        end
    end

    assign bus.ringing     = (state == RINGING);
    assign bus.snoozing    = (state == SNOOZE);
    assign bus.buzzer      = (state == RINGING) & beepPhase;
    assign bus.snoozeCount = snoozeCnt;
    assign {bus.tgtHourTens, bus.tgtHourMu, bus.tgtMinTens, bus.tgtMinMu} = tgt;
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench: a minute-count reference model predicts outputs per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_alarm_ring_ctrl;
    localparam int SN = 5;
    localparam int RT = 600;
    localparam int MX = 3;

    typedef struct packed {
        logic        ring;
        logic        snz;
        logic        buz;
        logic [1:0]  cnt;
        logic [15:0] tgt;
    } expT;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    alarm_ring_ctrl_if bus ();

    alarm_ring_ctrl #(.SNOOZE_MIN(SN), .RING_TICKS(RT), .MAX_SNOOZE(MX)) dut (
        .clk10hz (clk),
        .nReset  (nReset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    expT sb[$];

    // Model state: mode 0 idle, 1 ringing, 2 snoozed, 3 locked out
    int mMode = 0, mEl = 0, mSnz = 0, mTgt = 0;
    bit mPS = 0, mPT = 0;
    int tH = 0, tM = 0, aH = 0, aM = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] bcdOf(input int mins);
        int h, m;
        h = mins / 60;
        m = mins % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expT e;
            e = sb.pop_front();
            check("ringing", 16'(bus.ringing), 16'(e.ring));
            check("snoozing", 16'(bus.snoozing), 16'(e.snz));
            check("buzzer", 16'(bus.buzzer), 16'(e.buz));
            check("snoozeCount", 16'(bus.snoozeCount), 16'(e.cnt));
            check("target", {bus.tgtHourTens, bus.tgtHourMu, bus.tgtMinTens, bus.tgtMinMu}, e.tgt);
        end
    end

    task automatic drv();
        bus.timeHourTens  = 4'(tH / 10);
        bus.timeHourMu    = 4'(tH % 10);
        bus.timeMinTens   = 4'(tM / 10);
        bus.timeMinMu     = 4'(tM % 10);
        bus.alarmHourTens = 4'(aH / 10);
        bus.alarmHourMu   = 4'(aH % 10);
        bus.alarmMinTens  = 4'(aM / 10);
        bus.alarmMinMu    = 4'(aM % 10);
    endtask

    task automatic setT(input int h, input int m);
        tH = h; tM = m; drv();
    endtask

    task automatic setA(input int h, input int m);
        aH = h; aM = m; drv();
    endtask

    // Advance the model over one edge using the pre-edge inputs, then push its prediction
    task automatic step();
        bit se, te;
        int tNow, aNow;
        expT e;
        if (!nReset) begin
            mMode = 0; mEl = 0; mSnz = 0; mTgt = 0; mPS = 0; mPT = 0;
        end else begin
            se = bus.snoozeBtn && !mPS;
            te = bus.stopBtn && !mPT;
            mPS = bus.snoozeBtn;
            mPT = bus.stopBtn;
            tNow = tH * 60 + tM;
            aNow = aH * 60 + aM;
            case (mMode)
                0: begin
                    mTgt = aNow;
                    if (tNow == aNow && bus.alarmOn && !bus.setActive) begin
                        mMode = 1; mEl = 0;
                    end
                end
                1: begin
                    if (te || !bus.alarmOn || mEl == RT - 1) begin
                        mMode = 3; mSnz = 0;
                    end else if (se && mSnz < MX) begin
                        mMode = 2; mSnz++; mTgt = (tNow + SN) % 1440;
                    end else begin
                        mEl++;
                    end
                end
                2: begin
                    if (te || !bus.alarmOn) begin
                        mMode = 3; mSnz = 0;
                    end else if (tNow == mTgt) begin
                        mMode = 1; mEl = 0;
                    end
                end
                default: begin
                    mTgt = aNow;
                    if (tNow != aNow) mMode = 0;
                end
            endcase
        end
        e.ring = (mMode == 1);
        e.snz  = (mMode == 2);
        e.buz  = (mMode == 1) && (mEl % 2 == 0);
        e.cnt  = 2'(mSnz);
        e.tgt  = bcdOf(mTgt);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pressSnooze();
        bus.snoozeBtn = 1'b1; step();
        bus.snoozeBtn = 1'b0; step();
    endtask

    task automatic pressStop();
        bus.stopBtn = 1'b1; step();
        bus.stopBtn = 1'b0; step();
    endtask

    initial begin
        bus.alarmOn = 1'b0; bus.setActive = 1'b0;
        bus.snoozeBtn = 1'b0; bus.stopBtn = 1'b0;
        setA(7, 30); setT(7, 29);
        run(3);
        nReset = 1'b1;
        bus.alarmOn = 1'b1;

        // Basic ring, full timeout, lockout until the minute changes
        run(3);
        setT(7, 30); run(RT + 10);
        setT(7, 31); run(4);

        // Snooze across midnight; alarm edit during snooze is ignored
        setA(23, 58); setT(23, 57); run(2);
        setT(23, 58); run(4);
        pressSnooze();
        setA(6, 0); run(3);
        setT(0, 1); run(3);
        setT(0, 3); run(5);
        pressStop();
        setT(0, 4); run(3);

        // Hour-digit roll and the snooze limit; a held button gives one edge
        setA(9, 57); setT(9, 56); run(2);
        setT(9, 57); run(3);
        bus.snoozeBtn = 1'b1; run(3);
        setT(10, 2); run(4);
        bus.snoozeBtn = 1'b0; run(1);
        pressSnooze(); setT(10, 7); run(3);
        pressSnooze(); setT(10, 12); run(3);
        pressSnooze(); run(4);
        pressStop(); setT(10, 13); run(3);

        // Snooze and stop in the same cycle after one snooze
        setA(12, 0); setT(11, 59); run(2);
        setT(12, 0); run(3);
        pressSnooze(); setT(12, 5); run(3);
        bus.snoozeBtn = 1'b1; bus.stopBtn = 1'b1; step();
        bus.snoozeBtn = 1'b0; bus.stopBtn = 1'b0; run(3);
        setT(12, 6); run(2);

        // Suppression by setActive and alarmOn; alarmOn dropped mid-snooze
        setA(15, 30); setT(15, 29); run(2);
        bus.setActive = 1'b1; setT(15, 30); run(3);
        bus.setActive = 1'b0; bus.alarmOn = 1'b0; setT(15, 31); run(2);
        setT(15, 30); run(3);
        bus.alarmOn = 1'b1; setT(15, 31); run(2);
        setA(16, 0); setT(16, 0); run(3);
        pressSnooze(); bus.alarmOn = 1'b0; run(3);
        bus.alarmOn = 1'b1; setT(16, 5); run(4);
        setT(16, 6); run(2);

        // Asynchronous reset mid-ring, restart while time still matches
        setA(14, 0); setT(13, 59); run(2);
        setT(14, 0); run(6);
        nReset = 1'b0;
        #1;
        check("async ringing", 16'(bus.ringing), 16'd0);
        check("async buzzer", 16'(bus.buzzer), 16'd0);
        check("async snoozing", 16'(bus.snoozing), 16'd0);
        check("async target", {bus.tgtHourTens, bus.tgtHourMu, bus.tgtMinTens, bus.tgtMinMu}, 16'd0);
        sb.delete();
        run(2);
        nReset = 1'b1;
        run(5);
        pressStop(); setT(14, 1); run(2);

        // Randomised traffic around the alarm and snooze targets
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                if (tM == 59) setT((tH + 1) % 24, 0);
                else setT(tH, tM + 1);
            end else if (r < 13 && mMode == 2) begin
                setT(mTgt / 60, mTgt % 60);
            end else if (r < 16) begin
                setT(aH, aM);
            end
            if ($urandom_range(0, 5) == 0) bus.snoozeBtn = ~bus.snoozeBtn;
            if ($urandom_range(0, 24) == 0) bus.stopBtn = ~bus.stopBtn;
            if ($urandom_range(0, 79) == 0) bus.alarmOn = ~bus.alarmOn;
            if ($urandom_range(0, 59) == 0) bus.setActive = ~bus.setActive;
            if ($urandom_range(0, 199) == 0) begin
                int nm;
                nm = (tH * 60 + tM + int'($urandom_range(0, 3))) % 1440;
                setA(nm / 60, nm % 60);
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
